// File: rtl/clk_div_monitor.sv
// clk_div_monitor
//
// Receiving-end checker for a clock divider running in the same clk domain.
// The divided clock is sampled on every clk rising edge. Its period and high
// time are measured in clk cycles. Lock is declared after LOCK_CNT consecutive
// good periods. Wrong ratios and a stalled divided clock raise a sticky error.
//
// Parameters
//   DIV      expected divide ratio in clk cycles (>= 2)
//   CNT_W    counter / measurement width, 2^CNT_W - 1 >= 2*DIV
//   LOCK_CNT consecutive good periods needed for lock (>= 1)
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   clk_div_in  divided clock under test (synchronous to clk)
//   err_clr     one-cycle pulse clearing the sticky err
//   meas_valid  one-cycle pulse when period_o/high_o are updated
//   period_o    last measured period in clk cycles
//   high_o      high samples in the last measured period
//   locked      ratio confirmed
//   err         sticky error (bad period or timeout)
//   timeout     one-cycle pulse when the divided clock stalls
module clk_div_monitor #(
  parameter int DIV      = 7,
  parameter int CNT_W    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  input  logic             err_clr,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int GW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_C   = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] HALF_LO = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] HALF_HI = CNT_W'((DIV + 1) / 2);
  // The stall pulse is registered on the edge where cnt becomes 2*DIV,
  // so the condition looks at the value one below.
  localparam logic [CNT_W-1:0] TO_PRE  = CNT_W'(2 * DIV - 1);

  localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GOOD_FULL = GW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic             s_p0, s_p1;
  logic             rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [GW-1:0]    good_cnt, good_nxt;
  logic             locked_nxt;
  logic             err_set;
  logic             publish;
  logic             timeout_nxt;
  logic             good_period;
  logic             stall;

  // Saturating increment shared by the period and high counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end
    return v;
  endfunction

  // ---- stage p0/p1: sample the divided clock and detect its rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
    end else begin
      s_p0 <= clk_div_in;
      s_p1 <= s_p0;
    end
  end

  assign rise = s_p0 & ~s_p1;

  // ---- stage p2: period and high-time counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (rise) begin
      cnt  <= CNT_ONE;
      hcnt <= CNT_ONE;
    end else begin
      cnt  <= sat_inc(cnt, 1'b1);
      hcnt <= sat_inc(hcnt, s_p0);
    end
  end

  // cnt/hcnt still hold the finished period while rise is true.
  assign good_period = (cnt == DIV_C) && ((hcnt == HALF_LO) || (hcnt == HALF_HI));
  assign stall       = !rise && (cnt == TO_PRE);

  always_comb begin
    state_nxt   = state;
    good_nxt    = good_cnt;
    locked_nxt  = locked;
    err_set     = 1'b0;
    publish     = 1'b0;
    timeout_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        // First edge only starts a period; nothing to publish yet.
        if (rise) begin
          state_nxt = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          publish = 1'b1;
          if (good_period) begin
            if (good_cnt == GOOD_LAST) begin
              good_nxt   = GOOD_FULL;
              locked_nxt = 1'b1;
              state_nxt  = LOCKED;
            end else begin
              good_nxt = good_cnt + GOOD_ONE;
            end
          end else begin
            good_nxt = '0;
            err_set  = 1'b1;
          end
        end else if (stall) begin
          timeout_nxt = 1'b1;
          err_set     = 1'b1;
          locked_nxt  = 1'b0;
          good_nxt    = '0;
          state_nxt   = IDLE;
        end
      end
      LOCKED: begin
        if (rise) begin
          publish = 1'b1;
          if (!good_period) begin
            locked_nxt = 1'b0;
            err_set    = 1'b1;
            good_nxt   = '0;
            state_nxt  = MEASURE;
          end
        end else if (stall) begin
          timeout_nxt = 1'b1;
          err_set     = 1'b1;
          locked_nxt  = 1'b0;
          good_nxt    = '0;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        good_nxt   = '0;
        locked_nxt = 1'b0;
      end
    endcase
  end

  // ---- stage p3: registered state and outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      good_cnt   <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      meas_valid <= 1'b0;
      period_o   <= '0;
      high_o     <= '0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_nxt;
      locked     <= locked_nxt;
      timeout    <= timeout_nxt;
      meas_valid <= publish;
      // A new error wins over a simultaneous clear.
      if (err_set) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (publish) begin
        period_o <= cnt;
        high_o   <= hcnt;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
module tb_clk_div_monitor;

  localparam int DIV      = 7;
  localparam int CNT_W    = 8;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_div_in;
  logic             err_clr;
  logic             meas_valid;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             locked;
  logic             err;
  logic             timeout;

  clk_div_monitor #(.DIV(DIV), .CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_div_in (clk_div_in),
    .err_clr    (err_clr),
    .meas_valid (meas_valid),
    .period_o   (period_o),
    .high_o     (high_o),
    .locked     (locked),
    .err        (err),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic             cap_mv, cap_locked, cap_err;
  logic [CNT_W-1:0] cap_per, cap_high;
  int               to_cnt, to_idx;
  int               to_total = 0;

  initial begin
    #200000;
    $display("FAIL watchdog: got time-limit expiry expected completion");
    $fatal(1, "watchdog");
  end

  // Drives one period: h high cycles then per-h low cycles. The measurement
  // of the previous period is published two edges after the first high is
  // driven, so outputs are captured after the second edge (i == 1).
  task automatic drive_period(input int h, input int per, input int clr_at);
    to_cnt = 0;
    to_idx = -1;
    for (int i = 0; i < per; i++) begin
      clk_div_in = (i < h);
      err_clr    = (i == clr_at);
      @(posedge clk);
      #1;
      if (i == 1) begin
        cap_mv     = meas_valid;
        cap_per    = period_o;
        cap_high   = high_o;
        cap_locked = locked;
        cap_err    = err;
      end
      if (timeout) begin
        to_cnt++;
        to_total++;
        to_idx = i;
      end
    end
    err_clr = 1'b0;
  endtask

  task automatic test_reset;
    rst        = 1'b0;
    clk_div_in = 1'b0;
    err_clr    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL reset_mv: got %0b expected 0", meas_valid); end
    vectors++; if (period_o !== 8'd0) begin miscompares++; $display("FAIL reset_period: got %0d expected 0", period_o); end
    vectors++; if (high_o !== 8'd0) begin miscompares++; $display("FAIL reset_high: got %0d expected 0", high_o); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %0b expected 0", err); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %0b expected 0", timeout); end
    rst = 1'b1;
    drive_period(0, 3, -1);
  endtask

  task automatic test_lock;
    int prev_h;
    int h;
    prev_h = 0;
    for (int k = 1; k <= 6; k++) begin
      h = (k % 2 == 1) ? 4 : 3;
      drive_period(h, 7, -1);
      if (k == 1) begin
        vectors++; if (cap_mv !== 1'b0) begin miscompares++; $display("FAIL lock_first_rise_mv: got %0b expected 0", cap_mv); end
      end else begin
        vectors++; if (cap_mv !== 1'b1) begin miscompares++; $display("FAIL lock_mv k=%0d: got %0b expected 1", k, cap_mv); end
        vectors++; if (cap_per !== 8'd7) begin miscompares++; $display("FAIL lock_period k=%0d: got %0d expected 7", k, cap_per); end
        vectors++; if (cap_high !== 8'(prev_h)) begin miscompares++; $display("FAIL lock_high k=%0d: got %0d expected %0d", k, cap_high, prev_h); end
        vectors++; if (cap_locked !== (k >= 5)) begin miscompares++; $display("FAIL lock_locked k=%0d: got %0b expected %0b", k, cap_locked, (k >= 5)); end
      end
      vectors++; if (cap_err !== 1'b0) begin miscompares++; $display("FAIL lock_err k=%0d: got %0b expected 0", k, cap_err); end
      prev_h = h;
    end
    vectors++; if (to_total !== 0) begin miscompares++; $display("FAIL lock_no_timeout: got %0d expected 0", to_total); end
  endtask

  task automatic test_bad_period;
    drive_period(3, 6, -1);
    vectors++; if (cap_locked !== 1'b1) begin miscompares++; $display("FAIL bad_pre_locked: got %0b expected 1", cap_locked); end
    drive_period(4, 7, -1);
    vectors++; if (cap_mv !== 1'b1) begin miscompares++; $display("FAIL bad_mv: got %0b expected 1", cap_mv); end
    vectors++; if (cap_per !== 8'd6) begin miscompares++; $display("FAIL bad_period: got %0d expected 6", cap_per); end
    vectors++; if (cap_high !== 8'd3) begin miscompares++; $display("FAIL bad_high: got %0d expected 3", cap_high); end
    vectors++; if (cap_locked !== 1'b0) begin miscompares++; $display("FAIL bad_locked: got %0b expected 0", cap_locked); end
    vectors++; if (cap_err !== 1'b1) begin miscompares++; $display("FAIL bad_err: got %0b expected 1", cap_err); end
    for (int k = 1; k <= 4; k++) begin
      drive_period(4, 7, -1);
      vectors++; if (cap_locked !== (k == 4)) begin miscompares++; $display("FAIL relock k=%0d: got %0b expected %0b", k, cap_locked, (k == 4)); end
      vectors++; if (cap_err !== 1'b1) begin miscompares++; $display("FAIL relock_err_sticky k=%0d: got %0b expected 1", k, cap_err); end
    end
  endtask

  task automatic test_err_clr_alone;
    drive_period(4, 7, 3);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL clr_alone_err: got %0b expected 0", err); end
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL clr_alone_locked: got %0b expected 1", locked); end
  endtask

  task automatic test_duty_and_clr_collision;
    drive_period(1, 7, -1);
    vectors++; if (cap_locked !== 1'b1) begin miscompares++; $display("FAIL duty_pre_locked: got %0b expected 1", cap_locked); end
    vectors++; if (cap_err !== 1'b0) begin miscompares++; $display("FAIL duty_pre_err: got %0b expected 0", cap_err); end
    // err_clr lands on the same edge that publishes the bad-duty period.
    drive_period(4, 7, 1);
    vectors++; if (cap_per !== 8'd7) begin miscompares++; $display("FAIL duty_period: got %0d expected 7", cap_per); end
    vectors++; if (cap_high !== 8'd1) begin miscompares++; $display("FAIL duty_high: got %0d expected 1", cap_high); end
    vectors++; if (cap_locked !== 1'b0) begin miscompares++; $display("FAIL duty_locked: got %0b expected 0", cap_locked); end
    vectors++; if (cap_err !== 1'b1) begin miscompares++; $display("FAIL duty_err_collision: got %0b expected 1", cap_err); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL duty_err_held: got %0b expected 1", err); end
  endtask

  task automatic test_timeout;
    for (int k = 1; k <= 4; k++) begin
      drive_period(4, 7, -1);
    end
    vectors++; if (cap_locked !== 1'b1) begin miscompares++; $display("FAIL to_pre_locked: got %0b expected 1", cap_locked); end
    // Held high for 20 cycles; err cleared early so the timeout must re-set it.
    drive_period(20, 20, 5);
    vectors++; if (cap_locked !== 1'b1) begin miscompares++; $display("FAIL to_meas_locked: got %0b expected 1", cap_locked); end
    vectors++; if (to_cnt !== 1) begin miscompares++; $display("FAIL to_pulse_count: got %0d expected 1", to_cnt); end
    vectors++; if (to_idx !== 14) begin miscompares++; $display("FAIL to_pulse_cycle: got %0d expected 14", to_idx); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err: got %0b expected 1", err); end
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL to_locked: got %0b expected 0", locked); end
    drive_period(0, 4, -1);
    for (int k = 1; k <= 5; k++) begin
      drive_period(4, 7, -1);
      if (k == 1) begin
        vectors++; if (cap_mv !== 1'b0) begin miscompares++; $display("FAIL to_idle_first_rise_mv: got %0b expected 0", cap_mv); end
      end
      if (k >= 4) begin
        vectors++; if (cap_locked !== (k == 5)) begin miscompares++; $display("FAIL to_relock k=%0d: got %0b expected %0b", k, cap_locked, (k == 5)); end
      end
    end
  endtask

  task automatic test_async_reset;
    vectors++; if (locked !== 1'b1) begin miscompares++; $display("FAIL ar_pre_locked: got %0b expected 1", locked); end
    #2;
    rst = 1'b0;
    #1;
    vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL ar_locked: got %0b expected 0", locked); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ar_err: got %0b expected 0", err); end
    vectors++; if (meas_valid !== 1'b0) begin miscompares++; $display("FAIL ar_mv: got %0b expected 0", meas_valid); end
    vectors++; if (period_o !== 8'd0) begin miscompares++; $display("FAIL ar_period: got %0d expected 0", period_o); end
    vectors++; if (high_o !== 8'd0) begin miscompares++; $display("FAIL ar_high: got %0d expected 0", high_o); end
    vectors++; if (timeout !== 1'b0) begin miscompares++; $display("FAIL ar_timeout: got %0b expected 0", timeout); end
    clk_div_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive_period(0, 3, -1);
    drive_period(4, 7, -1);
    vectors++; if (cap_mv !== 1'b0) begin miscompares++; $display("FAIL ar_first_rise_mv: got %0b expected 0", cap_mv); end
    vectors++; if (cap_locked !== 1'b0) begin miscompares++; $display("FAIL ar_first_rise_locked: got %0b expected 0", cap_locked); end
    drive_period(4, 7, -1);
    vectors++; if (cap_mv !== 1'b1) begin miscompares++; $display("FAIL ar_second_rise_mv: got %0b expected 1", cap_mv); end
    vectors++; if (cap_per !== 8'd7) begin miscompares++; $display("FAIL ar_second_period: got %0d expected 7", cap_per); end
    vectors++; if (cap_high !== 8'd4) begin miscompares++; $display("FAIL ar_second_high: got %0d expected 4", cap_high); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_period();
    test_err_clr_alone();
    test_duty_and_clr_collision();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Checks a divided clock against its expected ratio. The block samples a divided clock produced from the same `clk` domain (e.g. a divide-by-7 output) on every `clk` rising edge and measures its period and high time in `clk` cycles. It declares lock after a run of good periods, and flags wrong ratios or a stalled divided clock. It is the receiving-end checker placed beside each frequency divider.

## Interface
- `DIV`, default 7: expected divide ratio in `clk` cycles; legal range 2 or more.
- `CNT_W`, default 8: counter and measurement width; must satisfy 2^CNT_W − 1 ≥ 2·DIV.
- `LOCK_CNT`, default 4: number of consecutive good periods required to assert lock; legal range 1 or more.
- `clk`  input  1  system clock; all logic runs on its rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `clk_div_in`  input  1  divided clock under test. It is synchronous to `clk`; no synchronizer.
- `err_clr`  input  1  one-cycle pulse that clears the sticky `err`.
- `meas_valid`  output  1  one-cycle pulse when a new measurement is published.
- `period_o`  output  CNT_W  last measured period, in `clk` cycles.
- `high_o`  output  CNT_W  number of samples that were high in the last measured period.
- `locked`  output  1  asserted while the ratio is confirmed.
- `err`  output  1  sticky error: bad period or timeout.
- `timeout`  output  1  one-cycle pulse when the divided clock is detected as stalled.

## Operation
- Sampling:
  - `s` = `clk_div_in` registered once; `p` = `s` registered again.
  - `rise` = `s & ~p`.
- Period counter `cnt`:
  - Loads 1 on `rise`.
  - Otherwise increments, saturating at 2^CNT_W − 1.
- High counter `hcnt`:
  - Loads 1 on `rise`.
  - Otherwise adds `s`, saturating.
- On `rise` in states MEASURE or LOCKED:
  - `period_o` ← `cnt` and `high_o` ← `hcnt`, both the pre-update values.
  - `meas_valid` pulses.
- Good period: `period_o == DIV` and `high_o` ∈ {⌊DIV/2⌋, ⌈DIV/2⌉}. Both bounds are accepted because a both-edge divider sampled on `posedge` shows a 3/4 split at DIV = 7.
- States:
  - IDLE: wait for the first `rise`, then go to MEASURE. No measurement is published on this first `rise`.
  - MEASURE: on a good period, `good_cnt`++. When `good_cnt` reaches LOCK_CNT, go to LOCKED and assert `locked`. On a bad period, set `good_cnt` ← 0 and set `err`.
  - LOCKED: a good period changes nothing. A bad period clears `locked`, sets `err`, sets `good_cnt` ← 0 and goes to MEASURE.
- Timeout:
  - Condition: in MEASURE or LOCKED, `cnt` reaches 2·DIV with no `rise`.
  - Action: pulse `timeout`, set `err`, clear `locked` and `good_cnt`, go to IDLE.
  - Timeout fires once per stall; IDLE does not time out.
- `err_clr` clears `err`. If a new error and `err_clr` occur in the same cycle, `err` remains set.
- Reset values (asynchronous, `rst` = 0):
  - State IDLE.
  - `s`, `p` = 0; `cnt`, `hcnt` = 0; `good_cnt` = 0.
  - `period_o`, `high_o` = 0.
  - `meas_valid`, `locked`, `err`, `timeout` = 0.
- Reset asserted mid-operation aborts immediately with no residual lock. Measurement restarts from IDLE after release.

## Timing
- `clk_div_in` sampled high first at edge N:
  - `rise` is true in the cycle after edge N.
  - `meas_valid`, `period_o`, `high_o`, `locked` and `err` update at edge N+1.
- Measurement latency is 2 edges from the first high sample.
- For a steady divide-by-DIV input, `meas_valid` pulses every DIV cycles.
- `locked` rises at the edge that publishes the LOCK_CNT-th good measurement. That is the (LOCK_CNT+1)-th `rise` after reset.
- `timeout` pulses 2·DIV − 1 cycles after the last `rise` cycle, i.e. when `cnt` reaches 2·DIV.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset release, then an ideal 50%-style divide-by-7 input (DIV = 7, LOCK_CNT = 4):
  - every `meas_valid` shows `period_o` = 7 and `high_o` = 3 or 4;
  - `locked` = 1 at the 5th `rise`;
  - `err` = 0 throughout.
- While locked, one period of 6 injected (high 3):
  - that `meas_valid` shows `period_o` = 6;
  - `locked` → 0, `err` → 1;
  - `locked` returns after 4 further good periods.
- While locked, one period of 7 with high = 1:
  - `err` = 1, `locked` = 0, proving the duty check.
- Input held high for 20 cycles after a `rise`:
  - `timeout` pulses exactly once, when `cnt` = 14;
  - state goes to IDLE; `err` = 1;
  - next good stream needs 1 + 4 rises to relock.
- `err_clr` pulsed alone → `err` = 0. `err_clr` in the same cycle as a bad period → `err` stays 1.
- `rst` driven low mid-lock between clock edges:
  - all outputs go to 0 immediately (asynchronously);
  - after release, the first `rise` produces no `meas_valid`.
